vdp_scandoubler: RTL
====================

VDP_SCANDOUBLER -- requirements
Module: vdp_scandoubler

Interface
REQ-001 SHALL have port: clk  input  1  system clock; one clock domain only.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: clk_en_in  input  1  VDP pixel-rate enable; samples sync_h, sync_v and color.
REQ-004 SHALL have port: clk_en_out  input  1  VGA pixel-rate enable; nominally exactly twice the clk_en_in rate.
REQ-005 SHALL have port: sync_h  input  1  VDP horizontal sync, active-low.
REQ-006 SHALL have port: sync_v  input  1  VDP vertical sync, active-low.
REQ-007 SHALL have port: color  input  [0:3]  VDP palette index.
REQ-008 SHALL have port: vga_hsync  output  1  doubled-rate horizontal sync, active-low.
REQ-009 SHALL have port: vga_vsync  output  1  vertical sync, active-low, aligned to output lines.
REQ-010 SHALL have port: vga_color  output  [0:3]  doubled-rate palette index.

Function
REQ-011 SHALL treat a falling sync_h sampled on clk_en_in as input line start: swap the ping-pong bank, reset the write pointer to 0, and latch line_len and hs_len.
REQ-012 SHALL write color into the current write bank at wr_ptr on each clk_en_in, then increment wr_ptr; wr_ptr SHALL saturate at 511, and writes at 511 SHALL be dropped.
REQ-013 SHALL count input ticks per line; line_len SHALL be min(count, 512), and hs_len SHALL be the count of sync_h-low ticks, saturating at 255.
REQ-014 SHALL read the previous (non-write) bank at rd_ptr on each clk_en_out, and vga_color SHALL register the read data with 1 clk_en_out of latency.
REQ-015 SHALL wrap rd_ptr to 0 after it reaches line_len-1, starting a second output line from the same buffer.
REQ-016 SHALL force rd_ptr to 0 on input line start, regardless of its current value, for resynchronisation.
REQ-017 SHALL drive vga_hsync low for the first hs_len clk_en_out ticks of each output line, so sync width in output ticks equals the input sync width in input ticks.
REQ-018 SHALL sample sync_v at input line start and present it on vga_vsync for both output lines, delaying vsync by exactly one input line.
REQ-019 SHALL give a total video latency of one input line plus 1 clk_en_out.
REQ-020 SHALL service clk_en_in and clk_en_out asserted in the same cycle independently in that cycle; because the read and write banks differ, there is no collision.
REQ-021 SHALL, if line_len is 0 (no pixels between syncs), output color 4'h0 and hold rd_ptr at 0.
REQ-022 SHALL hold all state while neither enable is asserted.

Reset
REQ-023 SHALL, during reset, hold vga_hsync=1, vga_vsync=1 and vga_color=4'h0.
REQ-024 SHALL reset to: bank=0, wr_ptr=0, rd_ptr=0, line_len=342, hs_len=26.
REQ-025 SHALL treat reset asserted mid-line identically to power-up, with the first valid output following the second input line start after reset.
REQ-026 SHALL NOT require the line-buffer contents to be reset.

Configuration
REQ-027 SHALL, with SCANDOUBLER_SCANLINES_EN defined, output vga_color=4'h1 (black) on the second output line of each pair, with sync unaffected.
REQ-028 SHALL, without SCANDOUBLER_SCANLINES_EN, output both lines of each pair identically from the buffer.

Structure
REQ-029 SHALL place LINEBUF_DEPTH=512, PTR_W=9, COLOR_BLACK=4'h1, RESET_LINE_LEN=342 and RESET_HS_LEN=26 in shared package vdp_scan_pkg.
REQ-030 SHALL implement storage in one sub-module, linebuf_dp: 2x512x4 simple dual-port RAM with a 1-clk synchronous read.

Verification
REQ-031 SHALL cover: 342-tick lines, sync_h low 26 ticks, ramp color=x mod 16 -> each output line shows the ramp twice per input line; vga_hsync low for 26 clk_en_out ticks.
REQ-032 SHALL cover: sync_v low for lines 3..5 -> vga_vsync low during output lines 8..13 (input lines 4..6).
REQ-033 SHALL cover: one 600-tick line -> line_len=512, no write beyond 511, and the next 342-tick line is reproduced correctly.
REQ-034 SHALL cover: reset asserted at tick 100 of a line -> outputs 1/1/0 immediately; correct video from the second sync after release.
REQ-035 SHALL cover: SCANDOUBLER_SCANLINES_EN with constant color 4'h7 -> output lines alternate 4'h7 and 4'h1.
REQ-036 SHALL cover: jittered clk_en_out (one extra tick per line) -> rd_ptr resyncs to 0 at each input line start, with no drift over 262 lines.

Source files
------------

// File: rtl/vdp_scan_pkg.sv
// rtl/vdp_scan_pkg.sv - shared constants, types and helpers for the VDP scandoubler
package vdp_scan_pkg;

  localparam int LINEBUF_DEPTH = 512;
  localparam int PTR_W         = 9;
  localparam int LEN_W         = PTR_W + 1;
  localparam int HS_W          = 8;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef logic [HS_W-1:0]  hs_t;
  typedef logic [3:0]       color_t;

  localparam color_t COLOR_BLACK    = 4'h1;
  localparam color_t COLOR_BLANK    = 4'h0;
  localparam len_t   RESET_LINE_LEN = 10'd342;
  localparam hs_t    RESET_HS_LEN   = 8'd26;
  localparam ptr_t   PTR_MAX        = 9'd511;
  localparam len_t   LEN_MAX        = 10'd512;
  localparam hs_t    HS_MAX         = 8'd255;

  // Flags travelling alongside a buffer read so sync lines up with its pixel.
  typedef struct packed {
    logic hs_low;
    logic vs;
    logic blank;
  } rd_stage_t;

  // True when p is the last pixel of a line of length len (never for an empty line).
  function automatic logic is_last_pixel(ptr_t p, len_t len);
    return (len != '0) && (len_t'(p) == len - len_t'(1));
  endfunction

endpackage

// File: rtl/vdp_scandoubler_if.sv
// rtl/vdp_scandoubler_if.sv - VDP input and VGA output video signals of the scandoubler
interface vdp_scandoubler_if;

  logic       clk_en_in;
  logic       clk_en_out;
  logic       sync_h;
  logic       sync_v;
  logic [0:3] color;
  logic       vga_hsync;
  logic       vga_vsync;
  logic [0:3] vga_color;

  modport master (
    output clk_en_in, clk_en_out, sync_h, sync_v, color,
    input  vga_hsync, vga_vsync, vga_color
  );

  modport slave (
    input  clk_en_in, clk_en_out, sync_h, sync_v, color,
    output vga_hsync, vga_vsync, vga_color
  );

endinterface

// File: rtl/linebuf_dp.sv
// rtl/linebuf_dp.sv - two-bank 512x4 simple dual-port line buffer with registered read
module linebuf_dp
  import vdp_scan_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  logic   wr_bank,
  input  ptr_t   wr_addr,
  input  color_t wr_data,
  input  logic   re,
  input  logic   rd_bank,
  input  ptr_t   rd_addr,
  output color_t rd_data
);

  color_t mem [0:2*LINEBUF_DEPTH-1];

  // Write port: bank selects the upper half of the array.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Read port: data appears one clk after an enabled read and then holds.
  always_ff @(posedge clk) begin
    if (re) rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/vdp_scandoubler.sv
// rtl/vdp_scandoubler.sv - VDP to VGA line doubler; SCANDOUBLER_SCANLINES_EN blacks every second output line
module vdp_scandoubler
  import vdp_scan_pkg::*;
(
  input logic             clk,
  input logic             reset,
  vdp_scandoubler_if.slave vid
);

  logic      sync_h_d;
  logic      bank;
  ptr_t      wr_ptr;
  len_t      in_cnt;
  hs_t       hs_cnt;
  len_t      line_len;
  hs_t       hs_len;
  logic      vs_samp;
  logic      vs_line;
  ptr_t      rd_ptr;
  rd_stage_t s1;
  rd_stage_t s1_nxt;
  color_t    rd_data;
  color_t    color_in;
  color_t    pix;
  logic      vga_hsync_q;
  logic      vga_vsync_q;
  color_t    vga_color_q;

  logic      line_start;
  logic      wr_bank_eff;
  ptr_t      wr_ptr_eff;
  logic      we;
  len_t      len_eff;
  hs_t       hs_eff;
  ptr_t      rptr_eff;
  logic      vs_eff;
  logic      re;
  logic      rd_wrap;
  ptr_t      rd_ptr_nxt;

`ifdef SCANDOUBLER_SCANLINES_EN
  logic      rd_half;
  logic      half_eff;
  logic      rd_half_nxt;
  logic      s1_half;
`endif

  assign color_in   = vid.color;
  assign line_start = vid.clk_en_in & sync_h_d & ~vid.sync_h;

  // Values as seen after a line start in this cycle, so reads coinciding with
  // the start already use the freshly swapped bank and latched lengths.
  always_comb begin
    wr_bank_eff = bank;
    wr_ptr_eff  = wr_ptr;
    len_eff     = line_len;
    hs_eff      = hs_len;
    rptr_eff    = rd_ptr;
    vs_eff      = vs_line;
    if (line_start) begin
      wr_bank_eff = ~bank;
      wr_ptr_eff  = '0;
      len_eff     = in_cnt;
      hs_eff      = hs_cnt;
      rptr_eff    = '0;
      vs_eff      = vs_samp;
    end
    we = vid.clk_en_in & (wr_ptr_eff != PTR_MAX);
    re = vid.clk_en_out & (len_eff != '0);
  end

`ifdef SCANDOUBLER_SCANLINES_EN
  assign half_eff = line_start ? 1'b0 : rd_half;
`endif

  // Read pointer advance with wrap, and the sync/blank flags for this read.
  always_comb begin
    rd_wrap    = is_last_pixel(rptr_eff, len_eff);
    rd_ptr_nxt = rptr_eff + ptr_t'(1);
    if (len_eff == '0 || rd_wrap) rd_ptr_nxt = '0;
    s1_nxt        = '0;
    s1_nxt.hs_low = len_t'(rptr_eff) < len_t'(hs_eff);
    s1_nxt.vs     = vs_eff;
    s1_nxt.blank  = (len_eff == '0);
`ifdef SCANDOUBLER_SCANLINES_EN
    rd_half_nxt = half_eff ^ rd_wrap;
`endif
  end

  linebuf_dp u_linebuf (
    .clk     (clk),
    .we      (we),
    .wr_bank (wr_bank_eff),
    .wr_addr (wr_ptr_eff),
    .wr_data (color_in),
    .re      (re),
    .rd_bank (~wr_bank_eff),
    .rd_addr (rptr_eff),
    .rd_data (rd_data)
  );

  // Input side: line start detection, write pointer, tick and sync-width counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_h_d <= 1'b1;
      bank     <= 1'b0;
      wr_ptr   <= '0;
      in_cnt   <= '0;
      hs_cnt   <= '0;
      line_len <= RESET_LINE_LEN;
      hs_len   <= RESET_HS_LEN;
      vs_samp  <= 1'b1;
      vs_line  <= 1'b1;
    end else if (vid.clk_en_in) begin
      sync_h_d <= vid.sync_h;
      bank     <= wr_bank_eff;
      wr_ptr   <= (wr_ptr_eff == PTR_MAX) ? PTR_MAX : wr_ptr_eff + ptr_t'(1);
      if (line_start) begin
        line_len <= in_cnt;
        hs_len   <= hs_cnt;
        vs_line  <= vs_samp;
        vs_samp  <= vid.sync_v;
        in_cnt   <= len_t'(1);
        hs_cnt   <= hs_t'(1);
      end else begin
        if (in_cnt != LEN_MAX) in_cnt <= in_cnt + len_t'(1);
        if (!vid.sync_h && hs_cnt != HS_MAX) hs_cnt <= hs_cnt + hs_t'(1);
      end
    end
  end

  // Read side: pointer walks the previous line twice, snapping to 0 at each input line start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      s1     <= '{hs_low: 1'b0, vs: 1'b1, blank: 1'b1};
`ifdef SCANDOUBLER_SCANLINES_EN
      rd_half <= 1'b0;
      s1_half <= 1'b0;
`endif
    end else if (vid.clk_en_out) begin
      rd_ptr <= rd_ptr_nxt;
      s1     <= s1_nxt;
`ifdef SCANDOUBLER_SCANLINES_EN
      rd_half <= rd_half_nxt;
      s1_half <= half_eff;
`endif
    end else if (line_start) begin
      rd_ptr <= '0;
`ifdef SCANDOUBLER_SCANLINES_EN
      rd_half <= 1'b0;
`endif
    end
  end

  // Pixel chosen for the output register: blank, scanline black, or buffer data.
  always_comb begin
    pix = rd_data;
`ifdef SCANDOUBLER_SCANLINES_EN
    if (s1_half) pix = COLOR_BLACK;
`endif
    if (s1.blank) pix = COLOR_BLANK;
  end

  // Output register, one clk_en_out behind the buffer read.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hsync_q <= 1'b1;
      vga_vsync_q <= 1'b1;
      vga_color_q <= COLOR_BLANK;
    end else if (vid.clk_en_out) begin
      vga_hsync_q <= ~s1.hs_low;
      vga_vsync_q <= s1.vs;
      vga_color_q <= pix;
    end
  end

  assign vid.vga_hsync = vga_hsync_q;
  assign vid.vga_vsync = vga_vsync_q;
  assign vid.vga_color = vga_color_q;

endmodule
